// File: rtl/cacheline_adaptor.sv
// Bridges a line-wide cache pmem port to a narrow burst memory port by
// splitting each line transfer into LINE_W/BURST_W beats.
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [LINE_W-1:0]   line_i,
    output logic [LINE_W-1:0]   line_o,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [BURST_W-1:0]  burst_i,
    output logic [BURST_W-1:0]  burst_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [LINE_W-1:0]  line_buf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            line_buf  <= '0;
            line_o    <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            resp_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_i) begin
                        address_o <= address_i & ALIGN_MASK;
                        cnt       <= '0;
                        read_o    <= 1'b1;
                        state     <= READ;
                    end else if (write_i) begin
                        address_o <= address_i & ALIGN_MASK;
                        line_buf  <= line_i;
                        cnt       <= '0;
                        write_o   <= 1'b1;
                        state     <= WRITE;
                    end
                end
                // Stalled cycles (resp_i low) leave data and counter untouched.
                READ: begin
                    if (resp_i) begin
                        line_o[int'(cnt)*BURST_W +: BURST_W] <= burst_i;
                        if (cnt == LAST_BEAT) begin
                            cnt    <= '0;
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        if (cnt == LAST_BEAT) begin
                            cnt     <= '0;
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write data follows the counter directly so each beat is ready the cycle it is strobed.
    always_comb begin
        burst_o = '0;
        if (state == WRITE) begin
            burst_o = line_buf[int'(cnt)*BURST_W +: BURST_W];
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, stalled reads, writes,
// writeback-then-load, mid-transfer reset and simultaneous requests.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks = 0;
    int errors = 0;

    int          ro_cnt;
    int          wo_cnt;
    int          resp_cnt;
    int          resp_cyc;
    logic [31:0] act_addr;
    logic [63:0] wq[$];
    logic        idle_resp = 1'b0;
    logic [7:0]  seed = 8'h00;

    localparam logic [255:0] EXP_RD    = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    localparam logic [255:0] EXP_SEED  = {{8{8'h4B}}, {8{8'h3C}}, {8{8'h2D}}, {8{8'h1E}}};
    localparam logic [255:0] LINE_WR   = {{8{8'hDD}}, {8{8'hCC}}, {8{8'hBB}}, {8{8'hAA}}};

    cacheline_adaptor dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat_pat(input int k);
        logic [7:0] b;
        b = 8'((k + 1) * 17) ^ seed;
        return {8{b}};
    endfunction

    // Holds the request until resp_o, strobes resp_i from pat while the adaptor is active,
    // and records what the memory and cache sides observed. Cycle 0 is the request cycle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [255:0] line, input logic [15:0] pat,
                                 input int len, input int ncyc);
        int   pidx;
        int   k;
        logic active;
        pidx = 0;
        k = 0;
        ro_cnt = 0;
        wo_cnt = 0;
        resp_cnt = 0;
        resp_cyc = -1;
        act_addr = '0;
        wq.delete();
        read_i = rd;
        write_i = wr;
        address_i = addr;
        line_i = line;
        for (int c = 0; c < ncyc; c++) begin
            active = read_o | write_o;
            if (read_o) ro_cnt++;
            if (write_o) wo_cnt++;
            if (resp_o) begin
                resp_cnt++;
                if (resp_cyc < 0) resp_cyc = c;
                read_i = 1'b0;
                write_i = 1'b0;
            end
            if (active) begin
                if (pidx == 0) begin
                    act_addr = address_o;
                    line_i = '1;
                    address_i = 32'hFFFF_FFC0;
                end
                resp_i = (pidx < len) ? pat[pidx] : 1'b0;
                pidx++;
            end else begin
                resp_i = idle_resp;
            end
            burst_i = beat_pat(k);
            if (active && resp_i) begin
                if (write_o) wq.push_back(burst_o);
                k++;
            end
            tick();
        end
        resp_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_n = 1'b0;
        line_i = '0;
        address_i = '0;
        read_i = 1'b0;
        write_i = 1'b0;
        burst_i = '0;
        resp_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_read_o", 256'(read_o), 256'(0));
        checkOutput("rst_write_o", 256'(write_o), 256'(0));
        checkOutput("rst_resp_o", 256'(resp_o), 256'(0));
        checkOutput("rst_line_o", line_o, 256'(0));
        checkOutput("rst_address_o", 256'(address_o), 256'(0));
        checkOutput("rst_burst_o", 256'(burst_o), 256'(0));
        reset_n = 1'b1;
        tick();

        $display("[TB] read without stalls");
        applyStimulus(1'b1, 1'b0, 32'h0000_1234, '0, 16'h000F, 4, 10);
        checkOutput("rd_addr", 256'(act_addr), 256'(32'h0000_1220));
        checkOutput("rd_read_cycles", 256'(ro_cnt), 256'(4));
        checkOutput("rd_write_cycles", 256'(wo_cnt), 256'(0));
        checkOutput("rd_resp_count", 256'(resp_cnt), 256'(1));
        checkOutput("rd_resp_cycle", 256'(resp_cyc), 256'(5));
        checkOutput("rd_line", line_o, EXP_RD);

        $display("[TB] read with stalls");
        seed = 8'h0F;
        applyStimulus(1'b1, 1'b0, 32'h0000_1234, '0, 16'h0069, 7, 14);
        checkOutput("stall_read_cycles", 256'(ro_cnt), 256'(7));
        checkOutput("stall_resp_count", 256'(resp_cnt), 256'(1));
        checkOutput("stall_resp_cycle", 256'(resp_cyc), 256'(8));
        checkOutput("stall_line", line_o, EXP_SEED);

        $display("[TB] write");
        applyStimulus(1'b0, 1'b1, 32'h0000_0345, LINE_WR, 16'h000F, 4, 10);
        checkOutput("wr_addr", 256'(act_addr), 256'(32'h0000_0340));
        checkOutput("wr_write_cycles", 256'(wo_cnt), 256'(4));
        checkOutput("wr_read_cycles", 256'(ro_cnt), 256'(0));
        checkOutput("wr_resp_count", 256'(resp_cnt), 256'(1));
        checkOutput("wr_resp_cycle", 256'(resp_cyc), 256'(5));
        checkOutput("wr_beat_count", 256'(wq.size()), 256'(4));
        for (int i = 0; i < wq.size(); i++) begin
            checkOutput($sformatf("wr_beat%0d", i), 256'(wq[i]), 256'(LINE_WR[i*64 +: 64]));
        end
        checkOutput("wr_line_o_kept", line_o, EXP_SEED);

        $display("[TB] writeback then load");
        seed = 8'h00;
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, LINE_WR, 16'h000F, 4, 6);
        checkOutput("wb_addr", 256'(act_addr), 256'(32'h0000_0100));
        checkOutput("wb_resp_count", 256'(resp_cnt), 256'(1));
        checkOutput("wb_read_cycles", 256'(ro_cnt), 256'(0));
        applyStimulus(1'b1, 1'b0, 32'h0000_0200, '0, 16'h000F, 4, 10);
        checkOutput("ld_addr", 256'(act_addr), 256'(32'h0000_0200));
        checkOutput("ld_resp_count", 256'(resp_cnt), 256'(1));
        checkOutput("ld_resp_cycle", 256'(resp_cyc), 256'(5));
        checkOutput("ld_write_cycles", 256'(wo_cnt), 256'(0));
        checkOutput("ld_line", line_o, EXP_RD);

        $display("[TB] reset mid-read");
        applyStimulus(1'b1, 1'b0, 32'h0000_0400, '0, 16'h000F, 4, 3);
        checkOutput("abort_pre_read_cycles", 256'(ro_cnt), 256'(2));
        read_i = 1'b0;
        resp_i = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("abort_read_o", 256'(read_o), 256'(0));
        checkOutput("abort_resp_o", 256'(resp_o), 256'(0));
        checkOutput("abort_line_o", line_o, 256'(0));
        checkOutput("abort_address_o", 256'(address_o), 256'(0));
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        checkOutput("abort_no_resp", 256'(resp_o), 256'(0));
        seed = 8'h0F;
        applyStimulus(1'b1, 1'b0, 32'h0000_ABCD, '0, 16'h000F, 4, 10);
        checkOutput("post_addr", 256'(act_addr), 256'(32'h0000_ABC0));
        checkOutput("post_read_cycles", 256'(ro_cnt), 256'(4));
        checkOutput("post_resp_cycle", 256'(resp_cyc), 256'(5));
        checkOutput("post_line", line_o, EXP_SEED);

        $display("[TB] simultaneous requests with idle strobes");
        seed = 8'h00;
        idle_resp = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h0000_0077, LINE_WR, 16'h000F, 4, 12);
        idle_resp = 1'b0;
        checkOutput("sim_addr", 256'(act_addr), 256'(32'h0000_0060));
        checkOutput("sim_read_cycles", 256'(ro_cnt), 256'(4));
        checkOutput("sim_write_cycles", 256'(wo_cnt), 256'(0));
        checkOutput("sim_resp_count", 256'(resp_cnt), 256'(1));
        checkOutput("sim_line", line_o, EXP_RD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
